// File: rtl/sample_pacer.sv
// Sample pacer: re-times ADC samples onto a fixed sample tick and
// flags samples that are lost (overrun) or missing (underrun).
module sample_pacer #(
    parameter int CLK_REF    = 50_000_000,
    parameter int SAMPL_T    = 1_000_000,
    parameter int FRQ_SIGNAL = 25_000,
    parameter int T          = CLK_REF / SAMPL_T,
    parameter int N          = SAMPL_T / FRQ_SIGNAL,
    localparam int IW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [15:0]   adc_data,
    input  logic          adc_valid,
    input  logic          clr_err,
    output logic          start,
    output logic [31:0]   o_signal,
    output logic          clk_en,
    output logic [IW-1:0] sample_idx,
    output logic          frame_start,
    output logic          overrun,
    output logic          underrun
);

    localparam int TW = $clog2(T);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [TW-1:0] tick_cnt;
    logic [15:0]   hold;
    logic          hold_full;
    logic          first;

    logic load;
    logic wr;
    logic to_idle;
    logic run_stay;
    logic ovr_set;
    logic und_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (run) state_nx = ARM;
            end
            ARM: begin
                if (!run)          state_nx = IDLE;
                else if (adc_valid) state_nx = RUN;
            end
            RUN: begin
                if (!run) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Load edge: tick_cnt steps T-2 -> T-1, so start is purely registered.
    assign run_stay = (state == RUN) && run;
    assign load     = run_stay && (tick_cnt == TW'(T - 2));
    assign wr       = adc_valid && run && (state != IDLE);
    assign to_idle  = (state != IDLE) && (state_nx == IDLE);
    assign ovr_set  = wr && hold_full && !load;
    assign und_set  = load && !hold_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start       <= 1'b0;
            frame_start <= 1'b0;
            clk_en      <= 1'b0;
            o_signal    <= '0;
            sample_idx  <= '0;
            tick_cnt    <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            first       <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            start       <= load;
            frame_start <= load &&
                           (first || sample_idx == IW'(N - 1));
            clk_en      <= (state_nx != IDLE);
            overrun     <= ovr_set || (overrun && !clr_err);
            underrun    <= und_set || (underrun && !clr_err);
            if (to_idle) begin
                hold_full  <= 1'b0;
                tick_cnt   <= '0;
                sample_idx <= '0;
                o_signal   <= '0;
                first      <= 1'b0;
            end else begin
                if (run_stay) begin
                    if (tick_cnt == TW'(T - 1)) tick_cnt <= '0;
                    else                        tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    tick_cnt <= '0;
                end
                if (state == ARM) first <= 1'b1;
                if (load) begin
                    first <= 1'b0;
                    if (hold_full) o_signal <= {{16{hold[15]}}, hold};
                    if (first || sample_idx == IW'(N - 1))
                        sample_idx <= '0;
                    else
                        sample_idx <= sample_idx + 1'b1;
                end
                // A write on the consume edge refills hold, so it stays full.
                if (wr)        hold_full <= 1'b1;
                else if (load) hold_full <= 1'b0;
                if (wr) hold <= adc_data;
            end
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer with a scoreboard of expected
// start-strobe payloads checked on the falling edge.
module tb_sample_pacer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        clr_err;
    logic        start;
    logic [31:0] o_signal;
    logic        clk_en;
    logic [5:0]  sample_idx;
    logic        frame_start;
    logic        overrun;
    logic        underrun;

    typedef struct {
        logic [31:0] sig;
        logic [5:0]  idx;
        logic        fs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic [31:0] last_sig;

    sample_pacer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .clr_err    (clr_err),
        .start      (start),
        .o_signal   (o_signal),
        .clk_en     (clk_en),
        .sample_idx (sample_idx),
        .frame_start(frame_start),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input logic [15:0] v);
        adc_data  = v;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] s, input int idx);
        exp_t e;
        e.sig = s;
        e.idx = 6'(idx);
        e.fs  = (idx == 0);
        q.push_back(e);
        last_sig = s;
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Send at a start (or ARM) cycle; the strobe must follow 50 cycles later.
    task automatic run_sample(input logic [15:0] v, input int idx);
        push(sext(v), idx);
        send(v);
        chk("start_width", start, 0);
        wait_cyc(48);
        chk("start_early", start, 0);
        tick();
        chk("start_due", start, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_clk_en"}, clk_en, 0);
        chk({tag, "_o_signal"}, o_signal, 0);
        chk({tag, "_idx"}, sample_idx, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_und"}, underrun, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && start) begin
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_start: got start=1 want no start");
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_o_signal", o_signal, e.sig);
                chk("sb_idx", sample_idx, e.idx);
                chk("sb_frame_start", frame_start, e.fs);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        clr_err   = 1'b0;
        last_sig  = '0;
        #2;
        chk_zero("rst");
        tick();
        tick();
        reset = 1'b0;
        run   = 1'b1;
        tick();
        chk("arm_clk_en", clk_en, 1);

        for (int i = 0; i <= 40; i++)
            run_sample(16'h8000 + 16'(i * 1237), i % 40);
        chk("steady_ovr", overrun, 0);
        chk("steady_und", underrun, 0);

        push(last_sig, 1);
        wait_cyc(50);
        chk("und_start", start, 1);
        chk("und_flag", underrun, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("und_clr", underrun, 0);

        push(32'h2, 2);
        send(16'h0001);
        send(16'h0002);
        chk("ovr_flag", overrun, 1);
        wait_cyc(47);
        chk("ovr_start", start, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovr_clr", overrun, 0);

        send(16'h0003);
        wait_cyc(47);
        push(32'h3, 3);
        push(32'h4, 4);
        send(16'h0004);
        chk("sim_start", start, 1);
        chk("sim_ovr", overrun, 0);
        wait_cyc(50);
        chk("sim_start2", start, 1);
        chk("sim_ovr2", overrun, 0);
        chk("sim_und2", underrun, 0);

        for (int j = 5; j <= 17; j++)
            run_sample(16'(16'hF000 - j * 333), j);
        chk("mid_idx", sample_idx, 17);
        run = 1'b0;
        tick();
        chk_zero("idle");
        send(16'h7777);
        tick();
        chk("idle_ign_start", start, 0);
        run = 1'b1;
        tick();
        chk("rearm_clk_en", clk_en, 1);
        run_sample(16'h1234, 0);

        send(16'h0005);
        send(16'h0006);
        chk("pre_rst_ovr", overrun, 1);
        wait_cyc(3);
        #3;
        reset     = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 16'h5555;
        #1;
        chk_zero("async");
        tick();
        tick();
        chk_zero("hold_rst");
        adc_valid = 1'b0;
        run       = 1'b0;
        reset     = 1'b0;
        wait_cyc(5);
        chk("post_rst_o_signal", o_signal, 0);
        chk("q_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
